// File: rtl/ant_update_scheduler_pkg.sv
// Shared game parameters: ant count, coordinate widths and playfield size,
// plus the bounds test used when screening proposed moves.
package ant_update_scheduler_pkg;
  localparam int ANT_num      = 4;
  localparam int ANT_num_bits = 2;
  localparam int X_bits       = 8;
  localparam int Y_bits       = 8;
  localparam logic [X_bits-1:0] PIXELS_X = X_bits'(160);
  localparam logic [Y_bits-1:0] PIXELS_Y = Y_bits'(120);

  function automatic logic in_bounds(input logic [X_bits-1:0] x, input logic [Y_bits-1:0] y);
    return (x < PIXELS_X) && (y < PIXELS_Y);
  endfunction
endpackage

// File: rtl/ant_update_scheduler_register.sv
// Loadable register with asynchronous active-low clear.
module ant_update_scheduler_register #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         RESET_n,
  input  logic         Ld,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) Q <= '0;
    else if (Ld) Q <= D;
  end
endmodule

// File: rtl/ant_update_scheduler.sv
// Walks every ant once per frame: fetch, screen the proposed move through the
// shared collision checker (with timeout), then strobe the result to ant memory.
module ant_update_scheduler
  import ant_update_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    Clk,
  input  logic                    RESET_n,
  input  logic                    SETUP_MODE,
  input  logic                    frame_tick,
  output logic [ANT_num_bits-1:0] ant_id,
  input  logic [X_bits-1:0]       prop_x,
  input  logic [Y_bits-1:0]       prop_y,
  output logic [X_bits-1:0]       collide_x,
  output logic [Y_bits-1:0]       collide_y,
  output logic                    collide_req,
  input  logic                    collide_ack,
  input  logic                    collision,
  output logic                    ant_we,
  output logic                    move_ok,
  output logic                    frame_busy,
  output logic                    frame_done,
  output logic                    frame_overrun
);
  typedef enum logic [2:0] {IDLE, FETCH, PROPOSE, COMMIT, NEXT} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ANT_num_bits-1:0] LAST_ID = ANT_num_bits'(ANT_num - 1);

  state_t                  state_reg;
  logic [CNT_W-1:0]        wait_cnt_reg;
  logic                    id_ld;
  logic [ANT_num_bits-1:0] id_next;

  // ant_id only moves on frame start, advance in NEXT, or a setup abort.
  always_comb begin
    id_ld   = 1'b0;
    id_next = '0;
    if (SETUP_MODE) begin
      id_ld = 1'b1;
    end else if (state_reg == IDLE && frame_tick) begin
      id_ld = 1'b1;
    end else if (state_reg == NEXT && ant_id != LAST_ID) begin
      id_ld   = 1'b1;
      id_next = ant_id + 1'b1;
    end
  end

  ant_update_scheduler_register #(.W(ANT_num_bits)) u_ant_id (
    .Clk     (Clk),
    .RESET_n (RESET_n),
    .Ld      (id_ld),
    .D       (id_next),
    .Q       (ant_id)
  );

  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      collide_x     <= '0;
      collide_y     <= '0;
      collide_req   <= 1'b0;
      ant_we        <= 1'b0;
      move_ok       <= 1'b0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      ant_we     <= 1'b0;
      frame_done <= 1'b0;
      if (frame_tick && frame_busy) frame_overrun <= 1'b1;

      if (SETUP_MODE) begin
        state_reg    <= IDLE;
        wait_cnt_reg <= '0;
        collide_req  <= 1'b0;
        frame_busy   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (frame_tick) begin
              state_reg  <= FETCH;
              frame_busy <= 1'b1;
            end
          end
          FETCH: state_reg <= PROPOSE;
          PROPOSE: begin
            // First PROPOSE cycle screens bounds; later cycles wait for the checker.
            if (!collide_req) begin
              if (!in_bounds(prop_x, prop_y)) begin
                move_ok   <= 1'b0;
                ant_we    <= 1'b1;
                state_reg <= COMMIT;
              end else begin
                collide_x    <= prop_x;
                collide_y    <= prop_y;
                collide_req  <= 1'b1;
                wait_cnt_reg <= '0;
              end
            end else if (collide_ack) begin
              move_ok      <= ~collision;
              collide_req  <= 1'b0;
              wait_cnt_reg <= '0;
              ant_we       <= 1'b1;
              state_reg    <= COMMIT;
            end else if (wait_cnt_reg == CNT_LIMIT) begin
              move_ok      <= 1'b0;
              collide_req  <= 1'b0;
              wait_cnt_reg <= '0;
              ant_we       <= 1'b1;
              state_reg    <= COMMIT;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
          end
          COMMIT: state_reg <= NEXT;
          NEXT: begin
            if (ant_id == LAST_ID) begin
              frame_done <= 1'b1;
              frame_busy <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              state_reg <= FETCH;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end
endmodule
